// File: rtl/mack_irq_controller_if.sv
// rtl/mack_irq_controller_if.sv - CPU-side bus bundle between the 68000 and the interrupt controller
interface mack_irq_controller_if;
  logic       AS_N;
  logic [2:0] FC;
  logic [2:0] ADDR;
  logic       CS_N;
  logic       RW;
  logic       REG_SEL;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic [2:0] IPL_N;
  logic       VPA_N;
  logic       DTACK_N;
  logic       IACK_N;

  modport master (output AS_N, FC, ADDR, CS_N, RW, REG_SEL, DIN,
                  input  DOUT, IPL_N, VPA_N, DTACK_N, IACK_N);
  modport slave  (input  AS_N, FC, ADDR, CS_N, RW, REG_SEL, DIN,
                  output DOUT, IPL_N, VPA_N, DTACK_N, IACK_N);
endinterface

// File: rtl/mack_irq_controller.sv
// rtl/mack_irq_controller.sv - 68000 interrupt controller: IRQ/timer priority encoding, autovector IACK, mask/pend registers
module mack_irq_controller #(
  parameter int         TIMER_BITS  = 16,
  parameter int         TIMER_LEVEL = 5,
  parameter logic [6:0] EDGE_MASK   = 7'h00
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [6:0]            IRQ_N,
  mack_irq_controller_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, IACK, REG} state_t;

  localparam logic [2:0] TLVL = 3'(TIMER_LEVEL);

  state_t                state;
  logic [6:0]            irq_s1, irq_s2, irq_prev;
  logic [6:0]            pend_q, fall, pend_eff, edge_clr;
  logic                  tpend_q, tpend_eff, tpend_clr, wrap;
  logic [TIMER_BITS-1:0] timer_cnt;
  logic [7:0]            mask;
  logic [7:0]            req;
  logic [2:0]            top_level;
  logic                  iack_start, reg_start, ack_hit;

  assign bus.IACK_N = ~(~bus.AS_N & (bus.FC == 3'b111));

  // Synchronisers idle high so reset never manufactures a falling edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      irq_s1   <= 7'h7f;
      irq_s2   <= 7'h7f;
      irq_prev <= 7'h7f;
    end else begin
      irq_s1   <= IRQ_N;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;
    end
  end

  always_comb begin
    // A fresh edge or wrap counts as pending in the same cycle, keeping latency at 3 clocks.
    fall      = irq_prev & ~irq_s2 & EDGE_MASK;
    pend_eff  = (EDGE_MASK & (pend_q | fall)) | (~EDGE_MASK & ~irq_s2);
    wrap      = &timer_cnt;
    tpend_eff = tpend_q | wrap;

    req = 8'h00;
    for (int l = 1; l <= 7; l++) begin
      req[l] = pend_eff[l-1] & ((l == 7) ? 1'b1 : mask[l-1]);
      if (l == TIMER_LEVEL) req[l] = req[l] | (tpend_eff & mask[7]);
    end
    top_level = 3'd0;
    for (int l = 1; l <= 7; l++) begin
      if (req[l]) top_level = 3'(l);
    end

    iack_start = (state == IDLE) & ~bus.AS_N & (bus.FC == 3'b111);
    reg_start  = (state == IDLE) & ~bus.AS_N & ~bus.CS_N & ~iack_start;
    ack_hit    = iack_start & req[bus.ADDR];

    edge_clr  = 7'h00;
    tpend_clr = 1'b0;
    if (ack_hit) begin
      // req[0] is never set, so ADDR is at least 1 here.
      edge_clr  = 7'(1) << (bus.ADDR - 3'd1);
      tpend_clr = (bus.ADDR == TLVL);
    end else if (reg_start & ~bus.RW & bus.REG_SEL) begin
      edge_clr  = bus.DIN[6:0];
      tpend_clr = bus.DIN[7];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q    <= 7'h00;
      tpend_q   <= 1'b0;
      timer_cnt <= '0;
      bus.IPL_N <= 3'b111;
    end else begin
      pend_q    <= ((pend_q & ~edge_clr) | fall) & EDGE_MASK;
      tpend_q   <= (tpend_q & ~tpend_clr) | wrap;
      timer_cnt <= timer_cnt + TIMER_BITS'(1);
      bus.IPL_N <= ~top_level;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      bus.VPA_N   <= 1'b1;
      bus.DTACK_N <= 1'b1;
      bus.DOUT    <= 8'h00;
      mask        <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (iack_start) begin
            state     <= IACK;
            bus.VPA_N <= 1'b0;
          end else if (reg_start) begin
            state       <= REG;
            bus.DTACK_N <= 1'b0;
            if (~bus.RW) begin
              if (~bus.REG_SEL) mask <= bus.DIN;
            end else begin
              bus.DOUT <= bus.REG_SEL ? {tpend_eff, pend_eff} : mask;
            end
          end
        end
        IACK: begin
          if (bus.AS_N) begin
            state     <= IDLE;
            bus.VPA_N <= 1'b1;
          end
        end
        REG: begin
          if (bus.AS_N) begin
            state       <= IDLE;
            bus.DTACK_N <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mack_irq_controller.sv
// tb/tb_mack_irq_controller.sv - self-checking bench for mack_irq_controller
module tb_mack_irq_controller;
  localparam int         TB_TIMER_BITS  = 4;
  localparam int         TB_TIMER_LEVEL = 5;
  localparam logic [6:0] TB_EDGE_MASK   = 7'h2A;
  localparam int         TPERIOD        = 1 << TB_TIMER_BITS;

  logic       CLK;
  logic       RST;
  logic [6:0] IRQ_N;

  mack_irq_controller_if bus();

  mack_irq_controller #(
    .TIMER_BITS (TB_TIMER_BITS),
    .TIMER_LEVEL(TB_TIMER_LEVEL),
    .EDGE_MASK  (TB_EDGE_MASK)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .IRQ_N(IRQ_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: sampled IRQ history, latched pendings, bus mode, cycles since reset.
  logic [6:0]  q_sync[$];
  logic [6:0]  m_pend;
  logic        m_tp;
  logic [7:0]  m_mask, m_dout;
  logic [2:0]  m_ipl;
  logic        m_vpa, m_dtack;
  int          m_mode;
  int unsigned m_cyc;

  typedef struct {
    logic [6:0] irq;
    logic [7:0] mask;
    logic [2:0] ipl;
    logic [6:0] pend;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_sync  = {7'h7f, 7'h7f, 7'h7f};
    m_pend  = 7'h00;
    m_tp    = 1'b0;
    m_mask  = 8'h00;
    m_dout  = 8'h00;
    m_ipl   = 3'b111;
    m_vpa   = 1'b1;
    m_dtack = 1'b1;
    m_mode  = 0;
    m_cyc   = 0;
  endtask

  task automatic tick();
    logic [6:0] fall, peff, clr, n_pend;
    logic       wrap, teff, tclr, n_tp, n_vpa, n_dtack, en;
    logic [7:0] r, n_mask, n_dout;
    int         best, n_mode;
    bit         iack_go, reg_go;
    fall = q_sync[0] & ~q_sync[1] & TB_EDGE_MASK;
    for (int i = 0; i < 7; i++)
      peff[i] = TB_EDGE_MASK[i] ? (m_pend[i] | fall[i]) : ~q_sync[1][i];
    wrap = ((m_cyc % TPERIOD) == TPERIOD - 1);
    teff = m_tp | wrap;
    r = 8'h00;
    best = 0;
    for (int lvl = 1; lvl <= 7; lvl++) begin
      en = (lvl == 7) ? 1'b1 : m_mask[lvl-1];
      if ((peff[lvl-1] && en) || (teff && m_mask[7] && lvl == TB_TIMER_LEVEL)) begin
        r[lvl] = 1'b1;
        best = lvl;
      end
    end
    iack_go = (m_mode == 0) && !bus.AS_N && (bus.FC == 3'b111);
    reg_go  = (m_mode == 0) && !bus.AS_N && !bus.CS_N && !iack_go;
    clr = 7'h00; tclr = 1'b0;
    n_mask = m_mask; n_dout = m_dout; n_mode = m_mode; n_vpa = m_vpa; n_dtack = m_dtack;
    if (iack_go) begin
      if (r[bus.ADDR]) begin
        clr[bus.ADDR - 3'd1] = 1'b1;
        tclr = (int'(bus.ADDR) == TB_TIMER_LEVEL);
      end
      n_mode = 1; n_vpa = 1'b0;
    end else if (reg_go) begin
      n_mode = 2; n_dtack = 1'b0;
      if (!bus.RW) begin
        if (bus.REG_SEL) begin
          clr  = bus.DIN[6:0];
          tclr = bus.DIN[7];
        end else begin
          n_mask = bus.DIN;
        end
      end else begin
        n_dout = bus.REG_SEL ? {teff, peff} : m_mask;
      end
    end else if (m_mode == 1 && bus.AS_N) begin
      n_mode = 0; n_vpa = 1'b1;
    end else if (m_mode == 2 && bus.AS_N) begin
      n_mode = 0; n_dtack = 1'b1;
    end
    n_pend = ((m_pend & ~clr) | fall) & TB_EDGE_MASK;
    n_tp   = (m_tp & ~tclr) | wrap;
    @(posedge CLK);
    q_sync.push_back(IRQ_N);
    void'(q_sync.pop_front());
    m_pend = n_pend; m_tp = n_tp; m_mask = n_mask; m_dout = n_dout;
    m_mode = n_mode; m_vpa = n_vpa; m_dtack = n_dtack;
    m_ipl  = ~3'(best);
    m_cyc++;
    @(negedge CLK);
    check("ipl", {5'b0, bus.IPL_N}, {5'b0, m_ipl});
    check("vpa", {7'b0, bus.VPA_N}, {7'b0, m_vpa});
    check("dtack", {7'b0, bus.DTACK_N}, {7'b0, m_dtack});
    check("dout", bus.DOUT, m_dout);
    check("iack_n", {7'b0, bus.IACK_N}, {7'b0, ~(~bus.AS_N & (bus.FC == 3'b111))});
  endtask

  task automatic bus_idle();
    bus.AS_N = 1'b1; bus.CS_N = 1'b1; bus.FC = 3'b000; bus.ADDR = 3'd0;
    bus.RW = 1'b1; bus.REG_SEL = 1'b0; bus.DIN = 8'h00;
  endtask

  task automatic reg_access(input logic rw, input logic sel, input logic [7:0] din);
    bus.AS_N = 1'b0; bus.CS_N = 1'b0; bus.FC = 3'b101;
    bus.RW = rw; bus.REG_SEL = sel; bus.DIN = din;
    tick();
    check("reg_dtack_low", {7'b0, bus.DTACK_N}, 8'h00);
    check("reg_vpa_high", {7'b0, bus.VPA_N}, 8'h01);
    tick();
    bus_idle();
    tick();
  endtask

  task automatic iack(input logic [2:0] lvl);
    bus.AS_N = 1'b0; bus.CS_N = 1'b1; bus.FC = 3'b111; bus.ADDR = lvl;
    tick();
    check("iack_vpa_low", {7'b0, bus.VPA_N}, 8'h00);
    check("iack_dtack_high", {7'b0, bus.DTACK_N}, 8'h01);
    tick();
    bus_idle();
    tick();
  endtask

  initial begin
    vecs[0] = '{irq: 7'h7f, mask: 8'h7f, ipl: 3'b111, pend: 7'h00};
    vecs[1] = '{irq: 7'h7b, mask: 8'h04, ipl: 3'b100, pend: 7'h04};
    vecs[2] = '{irq: 7'h7b, mask: 8'h00, ipl: 3'b111, pend: 7'h04};
    vecs[3] = '{irq: 7'h6a, mask: 8'h7f, ipl: 3'b010, pend: 7'h15};
    vecs[4] = '{irq: 7'h3f, mask: 8'h00, ipl: 3'b000, pend: 7'h40};
    vecs[5] = '{irq: 7'h3e, mask: 8'h01, ipl: 3'b000, pend: 7'h41};
    vecs[6] = '{irq: 7'h7e, mask: 8'h01, ipl: 3'b110, pend: 7'h01};
    vecs[7] = '{irq: 7'h6a, mask: 8'h05, ipl: 3'b100, pend: 7'h15};

    RST = 1'b1; IRQ_N = 7'h7f; bus_idle();
    model_reset();
    repeat (2) @(negedge CLK);
    check("rst_ipl", {5'b0, bus.IPL_N}, 8'h07);
    check("rst_vpa", {7'b0, bus.VPA_N}, 8'h01);
    check("rst_dtack", {7'b0, bus.DTACK_N}, 8'h01);
    check("rst_dout", bus.DOUT, 8'h00);
    RST = 1'b0;

    // Timer: counting from reset release, the first wrap lands on edge 16.
    reg_access(1'b1, 1'b0, 8'h00);
    check("mask_after_reset", bus.DOUT, 8'h00);
    reg_access(1'b0, 1'b0, 8'h80);
    repeat (9) tick();
    check("timer_before_wrap", {5'b0, bus.IPL_N}, 8'h07);
    tick();
    check("timer_at_clk16", {5'b0, bus.IPL_N}, 8'h02);
    iack(3'd5);
    check("timer_after_ack", {5'b0, bus.IPL_N}, 8'h07);
    reg_access(1'b0, 1'b0, 8'h00);

    foreach (vecs[k]) begin
      reg_access(1'b0, 1'b0, vecs[k].mask);
      IRQ_N = vecs[k].irq;
      repeat (4) tick();
      check($sformatf("vec%0d_ipl", k), {5'b0, bus.IPL_N}, {5'b0, vecs[k].ipl});
      reg_access(1'b1, 1'b1, 8'h00);
      check($sformatf("vec%0d_pend", k), {1'b0, bus.DOUT[6:0]}, {1'b0, vecs[k].pend});
    end
    IRQ_N = 7'h7f;
    repeat (3) tick();

    // Edge sources on levels 2 and 6, acknowledged highest first.
    reg_access(1'b0, 1'b0, 8'h22);
    IRQ_N = 7'h5d;
    repeat (2) tick();
    IRQ_N = 7'h7f;
    repeat (4) tick();
    check("edge_both_ipl", {5'b0, bus.IPL_N}, 8'h01);
    iack(3'd6);
    check("edge_after_ack6", {5'b0, bus.IPL_N}, 8'h05);
    reg_access(1'b0, 1'b1, 8'h02);
    tick();
    check("edge_after_w1c", {5'b0, bus.IPL_N}, 8'h07);

    // New synced edge on level 4 coincides with the IACK that would clear it.
    reg_access(1'b0, 1'b0, 8'h08);
    IRQ_N = 7'h77;
    repeat (2) tick();
    IRQ_N = 7'h7f;
    repeat (4) tick();
    check("l4_pend_ipl", {5'b0, bus.IPL_N}, 8'h03);
    IRQ_N = 7'h77;
    repeat (2) tick();
    iack(3'd4);
    check("set_beats_clear_ipl", {5'b0, bus.IPL_N}, 8'h03);
    reg_access(1'b1, 1'b1, 8'h00);
    check("set_beats_clear_pend", {7'b0, bus.DOUT[3]}, 8'h01);
    IRQ_N = 7'h7f;
    reg_access(1'b0, 1'b1, 8'h08);
    tick();
    check("l4_after_w1c", {5'b0, bus.IPL_N}, 8'h07);

    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 4))
        0: repeat ($urandom_range(1, 3)) tick();
        1: reg_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        2: iack(3'($urandom_range(0, 7)));
        3: begin
          IRQ_N = 7'($urandom);
          tick();
        end
        default: begin
          IRQ_N = 7'h7f;
          tick();
        end
      endcase
    end

    // Asynchronous reset in the middle of an IACK with a level-7 request active.
    IRQ_N = 7'h7f;
    repeat (3) tick();
    reg_access(1'b0, 1'b0, 8'h7f);
    reg_access(1'b1, 1'b0, 8'h00);
    IRQ_N = 7'h3f;
    repeat (4) tick();
    check("nmi_ipl", {5'b0, bus.IPL_N}, 8'h00);
    bus.AS_N = 1'b0; bus.FC = 3'b111; bus.ADDR = 3'd7;
    tick();
    check("pre_rst_vpa", {7'b0, bus.VPA_N}, 8'h00);
    #2 RST = 1'b1;
    #1;
    check("async_rst_vpa", {7'b0, bus.VPA_N}, 8'h01);
    check("async_rst_ipl", {5'b0, bus.IPL_N}, 8'h07);
    check("async_rst_dtack", {7'b0, bus.DTACK_N}, 8'h01);
    check("async_rst_dout", bus.DOUT, 8'h00);
    bus_idle();
    IRQ_N = 7'h7f;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    reg_access(1'b1, 1'b0, 8'h00);
    check("mask_after_async_rst", bus.DOUT, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
